// File: rtl/alu_pkg.sv
// Shared opcode encodings and data width for the ALU slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_NANDNOR = 3'b000;
    localparam logic [2:0] OP_ANDOR   = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_ADDSUB  = 3'b011;
    localparam logic [2:0] OP_SHL     = 3'b100;
    localparam logic [2:0] OP_SRAROL  = 3'b101;
    localparam logic [2:0] OP_SLT     = 3'b110;
    localparam logic [2:0] OP_PASS    = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and carry/borrow from operands, class and variant.
// Latency: 0 cycles (pure logic).
// Backpressure: none; output follows inputs continuously.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        control,
    input  logic              f,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [2:0]                sh;
    logic [DATA_W:0]           sum;
    logic [DATA_W:0]           diff;
    logic [2*DATA_W-1:0]       rot;
    logic signed [DATA_W-1:0]  sra;
    logic                      lt_u;
    logic                      lt_s;

    // Only the low three bits of b act as a shift/rotate amount.
    assign sh   = b[2:0];
    // Bit 8 of the 9-bit sum is the carry; bit 8 of the 9-bit difference is the borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // Rotate-left taken from the upper half of the doubled operand, so amount 0 returns a.
    assign rot  = {a, a} << sh;
    assign sra  = $signed(a) >>> sh;
    assign lt_u = (a < b);
    assign lt_s = ($signed(a) < $signed(b));

    // Select the operation result; carry is only meaningful for add/sub.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (control)
            OP_NANDNOR: result = f ? ~(a & b) : ~(a | b);
            OP_ANDOR:   result = f ? (a & b) : (a | b);
            OP_XOR:     result = f ? (a ^ b) : ~(a ^ b);
            OP_ADDSUB: begin
                result = f ? sum[DATA_W-1:0] : diff[DATA_W-1:0];
                carry  = f ? sum[DATA_W] : diff[DATA_W];
            end
            OP_SHL:     result = f ? (a >> sh) : (a << sh);
            OP_SRAROL:  result = f ? sra : rot[2*DATA_W-1:DATA_W];
            OP_SLT:     result = {{(DATA_W-1){1'b0}}, (f ? lt_u : lt_s)};
            OP_PASS:    result = f ? a : b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU with registered result, zero flag and carry/borrow flag.
// Latency: 1 cycle from inputs to c/zero/carry.
// Backpressure: none; a new operation is captured on every rising edge.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        control,
    input  logic              f,
    output logic [DATA_W-1:0] c,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W-1:0] res_nxt;
    logic              carry_nxt;
    logic              zero_nxt;

    alu_core u_core (
        .a       (a),
        .b       (b),
        .control (control),
        .f       (f),
        .result  (res_nxt),
        .carry   (carry_nxt)
    );

    // Zero is decoded from the next result so the flag lands on the same edge as c.
    assign zero_nxt = (res_nxt == '0);

    // Output register; reset clears the result and flags immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c     <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
        end else begin
            c     <= res_nxt;
            zero  <= zero_nxt;
            carry <= carry_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table, random vectors vs. a reference model, reset corners.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: none.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] control;
    logic       f;
    logic [7:0] c;
    logic       zero;
    logic       carry;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .control (control),
        .f       (f),
        .c       (c),
        .zero    (zero),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       f;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       z;
        logic       cy;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       z;
        logic       cy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, expv);
        end
    endtask

    // Independent reference: shifts/rotates stepped one bit at a time, arithmetic in int.
    function automatic exp_t model(input logic [2:0] op, input logic fl,
                                   input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   s;
        int   sx;
        int   sy;
        logic [7:0] r;
        r = 8'h00;
        e.cy = 1'b0;
        sx = x[7] ? int'(x) - 256 : int'(x);
        sy = y[7] ? int'(y) - 256 : int'(y);
        case (op)
            3'd0: r = fl ? ~(x & y) : ~(x | y);
            3'd1: r = fl ? (x & y) : (x | y);
            3'd2: r = fl ? (x ^ y) : (x ^ ~y);
            3'd3: begin
                if (fl) begin
                    s = int'(x) + int'(y);
                    e.cy = (s > 255);
                end else begin
                    s = int'(x) - int'(y) + 256;
                    e.cy = (int'(x) < int'(y));
                end
                r = s[7:0];
            end
            3'd4: begin
                r = x;
                for (int i = 0; i < int'(y[2:0]); i++) r = fl ? {1'b0, r[7:1]} : {r[6:0], 1'b0};
            end
            3'd5: begin
                r = x;
                for (int i = 0; i < int'(y[2:0]); i++) r = fl ? {r[7], r[7:1]} : {r[6:0], r[7]};
            end
            3'd6: r = fl ? ((int'(x) < int'(y)) ? 8'h01 : 8'h00) : ((sx < sy) ? 8'h01 : 8'h00);
            default: r = fl ? x : y;
        endcase
        e.c = r;
        e.z = (r == 8'h00);
        return e;
    endfunction

    // Drive inputs on the falling edge and record what the next rising edge must produce.
    task automatic drive(input logic [2:0] op, input logic fl, input logic [7:0] x,
                         input logic [7:0] y, input exp_t e);
        @(negedge clk);
        control = op;
        f       = fl;
        a       = x;
        b       = y;
        sb.push_back(e);
    endtask

    // Sample just after the rising edge and compare against the oldest expectation.
    task automatic check_out(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got c=0x%02h", tag, c);
        end else begin
            e = sb.pop_front();
            cmp({tag, "_c"}, c, e.c);
            cmp({tag, "_zero"}, {7'b0, zero}, {7'b0, e.z});
            cmp({tag, "_carry"}, {7'b0, carry}, {7'b0, e.cy});
        end
    endtask

    vec_t vecs[23];

    initial begin
        exp_t e;
        logic [2:0] rop;
        logic       rf;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0]  = '{3'b000, 1'b1, 8'h0F, 8'h05, 8'hFA, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 1'b0, 8'h0F, 8'h05, 8'hF0, 1'b0, 1'b0};
        vecs[2]  = '{3'b011, 1'b1, 8'h0F, 8'h05, 8'h14, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 1'b0, 8'h0F, 8'h05, 8'h0A, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 1'b1, 8'hAA, 8'h03, 8'hAD, 1'b0, 1'b0};
        vecs[5]  = '{3'b100, 1'b1, 8'h0F, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{3'b100, 1'b0, 8'h0F, 8'h05, 8'hE0, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{3'b011, 1'b0, 8'h05, 8'h0F, 8'hF6, 1'b0, 1'b1};
        vecs[9]  = '{3'b101, 1'b1, 8'h80, 8'h01, 8'hC0, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 1'b0, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 1'b0, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[12] = '{3'b110, 1'b1, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{3'b001, 1'b1, 8'h0F, 8'h05, 8'h05, 1'b0, 1'b0};
        vecs[14] = '{3'b001, 1'b0, 8'h0F, 8'h05, 8'h0F, 1'b0, 1'b0};
        vecs[15] = '{3'b010, 1'b1, 8'h0F, 8'h05, 8'h0A, 1'b0, 1'b0};
        vecs[16] = '{3'b010, 1'b0, 8'h0F, 8'h05, 8'hF5, 1'b0, 1'b0};
        vecs[17] = '{3'b111, 1'b1, 8'h0F, 8'h05, 8'h0F, 1'b0, 1'b0};
        vecs[18] = '{3'b111, 1'b0, 8'h0F, 8'h05, 8'h05, 1'b0, 1'b0};
        vecs[19] = '{3'b100, 1'b0, 8'hA5, 8'hF8, 8'hA5, 1'b0, 1'b0};
        vecs[20] = '{3'b101, 1'b0, 8'hA5, 8'h08, 8'hA5, 1'b0, 1'b0};
        vecs[21] = '{3'b101, 1'b1, 8'h81, 8'h07, 8'hFF, 1'b0, 1'b0};
        vecs[22] = '{3'b011, 1'b0, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};

        rst_n   = 1'b0;
        a       = 8'h5A;
        b       = 8'h3C;
        control = 3'b111;
        f       = 1'b1;

        // Reset values hold across a clock edge while rst_n is low.
        @(posedge clk);
        #1;
        cmp("reset_c", c, 8'h00);
        cmp("reset_zero", {7'b0, zero}, 8'h01);
        cmp("reset_carry", {7'b0, carry}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 23; i++) begin
            e.c  = vecs[i].c;
            e.z  = vecs[i].z;
            e.cy = vecs[i].cy;
            drive(vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b, e);
            check_out($sformatf("vec%0d", i));
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 48; i++) begin
            rop = 3'($urandom_range(0, 7));
            rf  = 1'($urandom_range(0, 1));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            drive(rop, rf, ra, rb, model(rop, rf, ra, rb));
            check_out($sformatf("rnd%0d_op%0d_f%0d", i, rop, rf));
        end

        // Asynchronous reset between edges while holding 0xAD.
        e = '{8'hAD, 1'b0, 1'b0};
        drive(3'b011, 1'b1, 8'hAA, 8'h03, e);
        check_out("pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_c", c, 8'h00);
        cmp("async_rst_zero", {7'b0, zero}, 8'h01);
        cmp("async_rst_carry", {7'b0, carry}, 8'h00);

        // Edge during reset must not capture the pending operation.
        @(negedge clk);
        control = 3'b111;
        f       = 1'b1;
        a       = 8'h0F;
        b       = 8'hFF;
        @(posedge clk);
        #1;
        cmp("held_rst_c", c, 8'h00);
        cmp("held_rst_zero", {7'b0, zero}, 8'h01);

        // First edge after release captures the current operation.
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{8'h0F, 1'b0, 1'b0});
        check_out("post_rst");

        // Inputs changing between edges leave the outputs alone until the next edge.
        a = 8'h77;
        #2;
        cmp("mid_cycle_hold_c", c, 8'h0F);
        sb.push_back('{8'h77, 1'b0, 1'b0});
        check_out("mid_cycle_next");

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; data width fixed at 8 bits.
REQ-002 Port order: clk, rst_n, a, b, control, f, c, zero, carry.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 a  input  8  operand A (InReg1).
REQ-006 b  input  8  operand B (InReg2); b[2:0] is the shift/rotate amount.
REQ-007 control  input  3  operation-class select.
REQ-008 f  input  1  variant select within the class (Flag).
REQ-009 c  output  8  registered result.
REQ-010 zero  output  1  registered; 1 when the registered c is 0x00.
REQ-011 carry  output  1  registered carry out (add) or borrow (sub); 0 for all other operations.

Function
REQ-012 Result combinationally selected from {control, f}, then registered into c on every rising clk edge; latency 1 cycle; no enable, no handshake.
REQ-013 control=000: f=1 -> c = ~(a & b) (NAND); f=0 -> c = ~(a | b) (NOR).
REQ-014 control=001: f=1 -> a & b; f=0 -> a | b.
REQ-015 control=010: f=1 -> a ^ b; f=0 -> ~(a ^ b).
REQ-016 control=011: f=1 -> a + b mod 256, carry = bit 8 of the 9-bit sum; f=0 -> a - b mod 256, carry = 1 when a < b unsigned.
REQ-017 control=100: f=1 -> a >> b[2:0] logical (zero fill); f=0 -> a << b[2:0] (zero fill); b[7:3] ignored.
REQ-018 control=101: f=1 -> arithmetic right shift of a by b[2:0] (sign fill); f=0 -> rotate a left by b[2:0].
REQ-019 control=110: f=1 -> c = 0x01 if a < b unsigned, else 0x00; f=0 -> same with signed two's-complement compare.
REQ-020 control=111: f=1 -> c = a; f=0 -> c = b.
REQ-021 Shift/rotate amount 0 -> c = a unchanged.
REQ-022 zero and carry are captured on the same edge as c and always correspond to it.
REQ-023 Inputs changing between edges have no effect on outputs until the next rising edge; there is no combinational path from inputs to outputs.

Reset
REQ-024 rst_n low asynchronously forces c=0x00, zero=1, carry=0, independent of clk.
REQ-025 While rst_n is low, outputs hold their reset values; the first rising edge after rst_n rises captures the current operation.
REQ-026 Reset asserted mid-operation discards the pending result; no state survives reset.

Structure
REQ-027 Shared package alu_pkg holds the 3-bit opcode constants (OP_NANDNOR=000, OP_ANDOR=001, OP_XOR=010, OP_ADDSUB=011, OP_SHL=100, OP_SRAROL=101, OP_SLT=110, OP_PASS=111) and the data-width constant (8).
REQ-028 One sub-module, alu_core, is natural: purely combinational {result, carry} from a, b, control, f; the alu top adds the output register and zero detection.

Verification
REQ-029 a=0x0F, b=0x05: {000,f=1} -> c=0xFA; {000,f=0} -> c=0xF0; each one edge after the inputs are applied.
REQ-030 a=0x0F, b=0x05: {011,f=1} -> c=0x14, carry=0; {011,f=0} -> c=0x0A, carry=0; then a=0xAA, b=0x03, {011,f=1} -> c=0xAD.
REQ-031 a=0x0F, b=0x05: {100,f=1} -> c=0x00, zero=1; {100,f=0} -> c=0xE0, zero=0.
REQ-032 Boundaries: a=0xFF, b=0x01 add -> c=0x00, carry=1, zero=1; a=0x05, b=0x0F sub -> c=0xF6, carry=1.
REQ-033 a=0x80, b=0x01: {101,f=1} -> c=0xC0; {101,f=0} -> c=0x01; {110,f=0} -> c=0x01; {110,f=1} -> c=0x00.
REQ-034 Drive rst_n low between clock edges while c=0xAD -> c=0x00, zero=1, carry=0 immediately, with no clk edge required.
